// File: rtl/adc_frame_align_if.sv
// Bus between the frame aligner and its surroundings: MMCM lock, deserialized FCLK word, realign
// request in; deserializer reset, bitslip and alignment status out. ADC_FRAME_ALIGN_STATS_EN adds relock_count.
interface adc_frame_align_if #(
  parameter int FRAME_WIDTH = 7
);
  logic                   mmcm_locked;
  logic [FRAME_WIDTH-1:0] frame_data;
  logic                   realign;
  logic                   serdes_rst;
  logic                   bitslip;
  logic                   aligned;
  logic                   align_error;
  logic [3:0]             slip_count;
`ifdef ADC_FRAME_ALIGN_STATS_EN
  logic [7:0]             relock_count;

  modport slave (
    input  mmcm_locked, frame_data, realign,
    output serdes_rst, bitslip, aligned, align_error, slip_count, relock_count
  );

  modport master (
    output mmcm_locked, frame_data, realign,
    input  serdes_rst, bitslip, aligned, align_error, slip_count, relock_count
  );
`else
  modport slave (
    input  mmcm_locked, frame_data, realign,
    output serdes_rst, bitslip, aligned, align_error, slip_count
  );

  modport master (
    output mmcm_locked, frame_data, realign,
    input  serdes_rst, bitslip, aligned, align_error, slip_count
  );
`endif
endinterface

// File: rtl/adc_frame_align.sv
// LVDS frame aligner: holds deserializers in reset until MMCM lock, bitslips until the FCLK word
// matches FRAME_PATTERN, then monitors for loss. Optional ADC_FRAME_ALIGN_STATS_EN adds relock_count.
module adc_frame_align #(
  parameter int                     FRAME_WIDTH   = 7,
  parameter logic [FRAME_WIDTH-1:0] FRAME_PATTERN = 7'b1111000,
  parameter int                     RST_CYCLES    = 8,
  parameter int                     SETTLE_CYCLES = 4,
  parameter int                     MATCH_COUNT   = 16,
  parameter int                     LOSS_COUNT    = 4,
  parameter int                     MAX_SLIPS     = 14
) (
  input logic              clk,
  input logic              reset,
  adc_frame_align_if.slave bus
);

  localparam int CYC_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CW      = $clog2(CYC_MAX + 1);
  localparam int MW      = $clog2(MATCH_COUNT + 1);
  localparam int LW      = $clog2(LOSS_COUNT + 1);

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCH_COUNT - 1);
  localparam logic [MW-1:0] MATCH_FULL  = MW'(MATCH_COUNT);
  localparam logic [LW-1:0] LOSS_LAST   = LW'(LOSS_COUNT - 1);
  localparam logic [3:0]    SLIP_MAX    = 4'(MAX_SLIPS);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    RST_HOLD,
    SETTLE,
    CHECK,
    SLIP,
    LOCKED,
    ERROR
  } state_t;

  state_t        state_q, state_d;
  logic          lock_p0, lock_p1;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [MW-1:0] match_q, match_d;
  logic [LW-1:0] loss_q, loss_d;
  logic [3:0]    slip_q, slip_d;
  logic          serdes_rst_q, serdes_rst_d;
  logic          bitslip_q, bitslip_d;
  logic          aligned_q, aligned_d;
  logic          err_q, err_d;
  logic          lock_s;
  logic          word_ok;
  logic          realign_ok;

  assign lock_s     = lock_p1;
  assign word_ok    = (bus.frame_data == FRAME_PATTERN);
  assign realign_ok = bus.realign &&
                      (state_q inside {SETTLE, CHECK, SLIP, LOCKED, ERROR});

  // Stage p0/p1: two-flop synchronizer for the asynchronous MMCM lock
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_p0 <= 1'b0;
      lock_p1 <= 1'b0;
    end else begin
      lock_p0 <= bus.mmcm_locked;
      lock_p1 <= lock_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT_LOCK;
      cyc_q        <= '0;
      match_q      <= '0;
      loss_q       <= '0;
      slip_q       <= '0;
      serdes_rst_q <= 1'b1;
      bitslip_q    <= 1'b0;
      aligned_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      match_q      <= match_d;
      loss_q       <= loss_d;
      slip_q       <= slip_d;
      serdes_rst_q <= serdes_rst_d;
      bitslip_q    <= bitslip_d;
      aligned_q    <= aligned_d;
      err_q        <= err_d;
    end
  end

  // Outputs are computed one cycle ahead so every port comes straight from a flop
  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    match_d      = match_q;
    loss_d       = loss_q;
    slip_d       = slip_q;
    serdes_rst_d = serdes_rst_q;
    bitslip_d    = 1'b0;
    aligned_d    = aligned_q;
    err_d        = err_q;

    if (!lock_s && (state_q != WAIT_LOCK)) begin
      state_d      = WAIT_LOCK;
      cyc_d        = '0;
      match_d      = '0;
      loss_d       = '0;
      slip_d       = '0;
      serdes_rst_d = 1'b1;
      aligned_d    = 1'b0;
      err_d        = 1'b0;
    end else if (realign_ok) begin
      state_d   = SETTLE;
      cyc_d     = '0;
      match_d   = '0;
      loss_d    = '0;
      slip_d    = '0;
      aligned_d = 1'b0;
      err_d     = 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          serdes_rst_d = 1'b1;
          cyc_d        = '0;
          if (lock_s) state_d = RST_HOLD;
        end
        RST_HOLD: begin
          if (cyc_q == RST_LAST) begin
            cyc_d        = '0;
            serdes_rst_d = 1'b0;
            state_d      = SETTLE;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        SETTLE: begin
          if (cyc_q == SETTLE_LAST) begin
            cyc_d   = '0;
            state_d = CHECK;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        CHECK: begin
          if (word_ok) begin
            if (match_q == MATCH_LAST) begin
              match_d   = MATCH_FULL;
              loss_d    = '0;
              aligned_d = 1'b1;
              state_d   = LOCKED;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
            if (slip_q == SLIP_MAX) begin
              err_d   = 1'b1;
              state_d = ERROR;
            end else begin
              // The strobe is launched on entry so it is high for exactly the SLIP cycle
              bitslip_d = 1'b1;
              slip_d    = slip_q + 1'b1;
              state_d   = SLIP;
            end
          end
        end
        SLIP: begin
          cyc_d   = '0;
          state_d = SETTLE;
        end
        LOCKED: begin
          aligned_d = 1'b1;
          if (word_ok) begin
            loss_d = '0;
          end else if (loss_q == LOSS_LAST) begin
            loss_d    = '0;
            match_d   = '0;
            slip_d    = '0;
            cyc_d     = '0;
            aligned_d = 1'b0;
            state_d   = SETTLE;
          end else begin
            loss_d = loss_q + 1'b1;
          end
        end
        ERROR: begin
          err_d = 1'b1;
        end
        default: begin
          state_d      = WAIT_LOCK;
          serdes_rst_d = 1'b1;
        end
      endcase
    end
  end

  assign bus.serdes_rst  = serdes_rst_q;
  assign bus.bitslip     = bitslip_q;
  assign bus.aligned     = aligned_q;
  assign bus.align_error = err_q;
  assign bus.slip_count  = slip_q;

`ifdef ADC_FRAME_ALIGN_STATS_EN
  logic [7:0] relock_q;
  logic       loss_exit;

  // Only the loss path counts; lock loss and realign take priority and never count
  assign loss_exit = lock_s && !bus.realign && (state_q == LOCKED) &&
                     !word_ok && (loss_q == LOSS_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      relock_q <= '0;
    end else if (loss_exit && (relock_q != 8'hFF)) begin
      relock_q <= relock_q + 8'd1;
    end
  end

  assign bus.relock_count = relock_q;
`endif

endmodule

// File: tb/tb_adc_frame_align.sv
// Directed bench for adc_frame_align with a rotating-deserializer model that reacts to bitslip.
module tb_adc_frame_align;

  localparam logic [6:0] PAT = 7'b1111000;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  adc_frame_align_if #(.FRAME_WIDTH(7)) bus ();

  adc_frame_align dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Deserializer model state
  bit model_en;
  int offset;
  int cyc;
  int nslips;
  int last_slip;
  int min_gap;
  int since_slip;

  function automatic logic [6:0] rotl(input logic [6:0] p, input int n);
    logic [13:0] d;
    d = {p, p} >> (7 - n);
    return d[6:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: sample #1 after the edge, then let the model react to a bitslip
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.bitslip) begin
      nslips++;
      if (last_slip >= 0 && (cyc - last_slip - 1) < min_gap) min_gap = cyc - last_slip - 1;
      last_slip  = cyc;
      since_slip = 0;
      if (model_en) begin
        offset = (offset == 0) ? 6 : offset - 1;
        bus.frame_data = rotl(PAT, offset);
      end
    end else begin
      since_slip++;
    end
  endtask

  task automatic pulse_realign();
    bus.realign = 1'b1;
    step();
    bus.realign = 1'b0;
  endtask

  initial begin
    int n;
    bit seen;
    reset           = 1'b1;
    bus.mmcm_locked = 1'b0;
    bus.realign     = 1'b0;
    model_en        = 1'b1;
    offset          = 3;
    bus.frame_data  = rotl(PAT, 3);
    cyc = 0; nslips = 0; last_slip = -1; min_gap = 1000; since_slip = 0;

    for (int i = 0; i < 20; i++) begin
      step();
      chk("rst_serdes_rst", bus.serdes_rst, 1);
      chk("rst_aligned", bus.aligned, 0);
      chk("rst_bitslip", bus.bitslip, 0);
      chk("rst_slip_count", bus.slip_count, 0);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("nolock_serdes_rst", bus.serdes_rst, 1);

    // 2 sync flops + WAIT_LOCK edge + 8 hold cycles
    bus.mmcm_locked = 1'b1;
    n = 0;
    while (bus.serdes_rst && n < 40) begin step(); n++; end
    chk("rst_release_latency", n, 11);

    n = 0;
    while (!bus.aligned && n < 400) begin step(); n++; end
    chk("align1_timeout", bus.aligned, 1);
    chk("align1_nslips", nslips, 3);
    chk("align1_gap_ge5", (min_gap >= 5), 1);
    chk("align1_slip_count", bus.slip_count, 3);
    chk("align1_latency", since_slip, 21);
    chk("align1_error", bus.align_error, 0);

    // No pattern rotation ever matches this word
    model_en       = 1'b0;
    bus.frame_data = 7'b0101010;
    nslips         = 0;
    pulse_realign();
    chk("realign_aligned", bus.aligned, 0);
    chk("realign_slip_count", bus.slip_count, 0);
    n = 0;
    while (!bus.align_error && n < 400) begin step(); n++; end
    chk("err_timeout", bus.align_error, 1);
    chk("err_nslips", nslips, 14);
    chk("err_slip_count", bus.slip_count, 14);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!bus.align_error) seen = 1'b1;
    end
    chk("err_no_more_slips", nslips, 14);
    chk("err_held", seen, 0);

    pulse_realign();
    chk("err_clear", bus.align_error, 0);
    chk("err_clear_slip_count", bus.slip_count, 0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.bitslip) seen = 1'b1;
    end
    chk("resume_settle_quiet", seen, 0);
    step();
    chk("resume_bitslip", bus.bitslip, 1);
    chk("resume_slip_count", bus.slip_count, 1);

    model_en       = 1'b1;
    offset         = 2;
    bus.frame_data = rotl(PAT, 2);
    pulse_realign();
    n = 0;
    while (!bus.aligned && n < 400) begin step(); n++; end
    chk("align2_timeout", bus.aligned, 1);
    chk("align2_slip_count", bus.slip_count, 2);

    // Loss monitor: 3 bad + 1 good keeps lock, 4 bad drops it
    model_en       = 1'b0;
    bus.frame_data = rotl(PAT, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("loss3_aligned", bus.aligned, 1);
    end
    bus.frame_data = PAT;
    step();
    chk("loss_good_aligned", bus.aligned, 1);
    bus.frame_data = rotl(PAT, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("loss4_pre_aligned", bus.aligned, 1);
    end
    step();
    chk("loss4_dropped", bus.aligned, 0);
    chk("loss4_slip_count", bus.slip_count, 0);
    model_en       = 1'b1;
    offset         = 0;
    bus.frame_data = PAT;
    n = 0;
    while (!bus.aligned && n < 400) begin step(); n++; end
    chk("relock_timeout", bus.aligned, 1);
    chk("relock_slip_count", bus.slip_count, 0);
`ifdef ADC_FRAME_ALIGN_STATS_EN
    chk("relock_count_1", bus.relock_count, 1);
`endif

    // Lock drop while the SLIP cycle is on the bus
    offset         = 1;
    bus.frame_data = rotl(PAT, 1);
    pulse_realign();
    n = 0;
    while (!bus.bitslip && n < 100) begin step(); n++; end
    chk("slipdrop_bitslip_seen", bus.bitslip, 1);
    bus.mmcm_locked = 1'b0;
    seen = 1'b0;
    // Two synchronizer edges, then the FSM edge
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.bitslip) seen = 1'b1;
    end
    chk("slipdrop_no_extra_pulse", seen, 0);
    chk("slipdrop_serdes_rst", bus.serdes_rst, 1);
    chk("slipdrop_slip_count", bus.slip_count, 0);
    chk("slipdrop_aligned", bus.aligned, 0);

    bus.mmcm_locked = 1'b1;
    n = 0;
    while (!bus.aligned && n < 400) begin step(); n++; end
    chk("relock2_timeout", bus.aligned, 1);
    chk("relock2_slip_count", bus.slip_count, 0);

    // realign and lock_s==0 reach the FSM on the same edge
    bus.mmcm_locked = 1'b0;
    step();
    step();
    chk("both_pre_aligned", bus.aligned, 1);
    pulse_realign();
    chk("both_serdes_rst", bus.serdes_rst, 1);
    chk("both_aligned", bus.aligned, 0);
    for (int i = 0; i < 3; i++) step();
    chk("both_stays_wait_lock", bus.serdes_rst, 1);
`ifdef ADC_FRAME_ALIGN_STATS_EN
    chk("both_relock_count", bus.relock_count, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
